// File: rtl/video_timing_pkg.sv
// Shared types, helper functions and timing presets for the raster timing generator.
package video_timing_pkg;

  // Raster run mode.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } vtg_state_e;

  // Pixels per line including blanking.
  function automatic int unsigned h_total(input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync,
                                          input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // Lines per frame including blanking.
  function automatic int unsigned v_total(input int unsigned active,
                                          input int unsigned fp,
                                          input int unsigned sync,
                                          input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // 640x480@60 timing, both syncs active-low.
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam bit          VGA_HS_POL   = 1'b0;
  localparam bit          VGA_VS_POL   = 1'b0;

  // Tiny raster (8x6 totals, 48 pixels per frame) for fast simulation.
  localparam int unsigned SMALL_H_ACTIVE = 4;
  localparam int unsigned SMALL_H_FP     = 1;
  localparam int unsigned SMALL_H_SYNC   = 2;
  localparam int unsigned SMALL_H_BP     = 1;
  localparam int unsigned SMALL_V_ACTIVE = 3;
  localparam int unsigned SMALL_V_FP     = 1;
  localparam int unsigned SMALL_V_SYNC   = 1;
  localparam int unsigned SMALL_V_BP     = 1;
  localparam bit          SMALL_HS_POL   = 1'b0;
  localparam bit          SMALL_VS_POL   = 1'b0;

endpackage

// File: rtl/video_timing_gen_axis.sv
// One raster axis: wrapping position counter plus decodes of its next position.
module timing_axis
  import video_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = 640,
  parameter int unsigned FP     = 16,
  parameter int unsigned SYNC   = 96,
  parameter int unsigned BP     = 48,
  parameter bit          POL    = 1'b0,
  parameter int unsigned CW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc_i,
  input  logic          clear_i,
  output logic [CW-1:0] count_o,
  output logic          wrap_c_o,
  output logic          active_nxt_c_o,
  output logic          sync_nxt_c_o
);

  localparam int unsigned TOTAL     = h_total(ACTIVE, FP, SYNC, BP);
  localparam int unsigned SYNC_BEG  = ACTIVE + FP;
  localparam int unsigned SYNC_END  = ACTIVE + FP + SYNC;

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          in_sync_c;

  // Last position of the axis: the next increment wraps to zero.
  assign wrap_c_o = (count_q == CW'(TOTAL - 1));

  // Next position: clear wins, otherwise increment with wrap.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = wrap_c_o ? '0 : count_q + CW'(1);
    end
  end

  // Decodes of the upcoming position so the parent can register them alongside the count.
  always_comb begin
    in_sync_c      = (count_d >= CW'(SYNC_BEG)) && (count_d < CW'(SYNC_END));
    active_nxt_c_o = (count_d < CW'(ACTIVE));
    sync_nxt_c_o   = in_sync_c ? POL : ~POL;
  end

  // Position register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: H/V counters, syncs, visible-area flag, strobes and run/drain/idle control.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_POL   = VGA_HS_POL,
  parameter bit          VS_POL   = VGA_VS_POL,
  parameter int unsigned CW       = 10,
  parameter int unsigned FCW      = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           run,
  output logic [CW-1:0]  counter_x,
  output logic [CW-1:0]  counter_y,
  output logic           h_sync,
  output logic           v_sync,
  output logic           draw_area,
  output logic           line_start,
  output logic           frame_start,
  output logic [FCW-1:0] frame_count,
  output logic           busy
);

  vtg_state_e     state_q;
  logic           h_sync_q;
  logic           v_sync_q;
  logic           draw_area_q;
  logic           line_start_q;
  logic           frame_start_q;
  logic [FCW-1:0] frame_count_q;
  logic           busy_q;

  logic           adv_c;
  logic           clear_c;
  logic           y_inc_c;
  logic           frame_end_c;
  logic           x_wrap_c;
  logic           y_wrap_c;
  logic           h_act_nxt_c;
  logic           v_act_nxt_c;
  logic           h_sync_nxt_c;
  logic           v_sync_nxt_c;

  // Counter control: advance only while generating, hold at the origin while idle.
  always_comb begin
    adv_c       = en && (state_q != IDLE);
    clear_c     = (state_q == IDLE);
    y_inc_c     = adv_c && x_wrap_c;
    frame_end_c = x_wrap_c && y_wrap_c;
  end

  timing_axis #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HS_POL),
    .CW     (CW)
  ) u_h_axis (
    .clk            (clk),
    .rst            (rst),
    .inc_i          (adv_c),
    .clear_i        (clear_c),
    .count_o        (counter_x),
    .wrap_c_o       (x_wrap_c),
    .active_nxt_c_o (h_act_nxt_c),
    .sync_nxt_c_o   (h_sync_nxt_c)
  );

  timing_axis #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VS_POL),
    .CW     (CW)
  ) u_v_axis (
    .clk            (clk),
    .rst            (rst),
    .inc_i          (y_inc_c),
    .clear_i        (clear_c),
    .count_o        (counter_y),
    .wrap_c_o       (y_wrap_c),
    .active_nxt_c_o (v_act_nxt_c),
    .sync_nxt_c_o   (v_sync_nxt_c)
  );

  // Mode FSM with registered decodes; strobes self-clear every clk so they stay one cycle wide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      h_sync_q      <= ~HS_POL;
      v_sync_q      <= ~VS_POL;
      draw_area_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_count_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (en) begin
        case (state_q)
          IDLE: begin
            if (run) begin
              state_q       <= RUN;
              busy_q        <= 1'b1;
              line_start_q  <= 1'b1;
              frame_start_q <= 1'b1;
              frame_count_q <= frame_count_q + FCW'(1);
              draw_area_q   <= h_act_nxt_c && v_act_nxt_c;
              h_sync_q      <= h_sync_nxt_c;
              v_sync_q      <= v_sync_nxt_c;
            end
          end
          RUN, DRAIN: begin
            if (frame_end_c && (state_q == DRAIN) && !run) begin
              // Drain complete: park at the origin with blanked outputs.
              state_q     <= IDLE;
              busy_q      <= 1'b0;
              draw_area_q <= 1'b0;
              h_sync_q    <= ~HS_POL;
              v_sync_q    <= ~VS_POL;
            end else begin
              state_q      <= run ? RUN : DRAIN;
              busy_q       <= 1'b1;
              draw_area_q  <= h_act_nxt_c && v_act_nxt_c;
              h_sync_q     <= h_sync_nxt_c;
              v_sync_q     <= v_sync_nxt_c;
              line_start_q <= x_wrap_c;
              if (frame_end_c) begin
                frame_start_q <= 1'b1;
                frame_count_q <= frame_count_q + FCW'(1);
              end
            end
          end
          default: begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign h_sync      = h_sync_q;
  assign v_sync      = v_sync_q;
  assign draw_area   = draw_area_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign frame_count = frame_count_q;
  assign busy        = busy_q;

endmodule
